// File: rtl/priority_encoder_8_3.sv
// priority_encoder_8_3: registered 8-to-3 priority encoder (bit 7 highest) with valid, one-hot and multi flags
module priority_encoder_8_3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] in,
  output logic [2:0] out,
  output logic       valid,
  output logic [7:0] onehot,
  output logic       multi
);
  logic [2:0] idx;
  logic       any;
  logic [7:0] hot;
  logic       many;
  always_comb begin
    idx  = in[7] ? 3'd7 : in[6] ? 3'd6 : in[5] ? 3'd5 : in[4] ? 3'd4 :
           in[3] ? 3'd3 : in[2] ? 3'd2 : in[1] ? 3'd1 : 3'd0;
    any  = |in;
    hot  = any ? 8'd1 << idx : 8'd0;
    many = |(in & (in - 8'd1));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out    <= 3'd0;
      valid  <= 1'b0;
      onehot <= 8'd0;
      multi  <= 1'b0;
    end else if (en) begin
      out    <= idx;
      valid  <= any;
      onehot <= hot;
      multi  <= many;
    end
  end
endmodule

// File: tb/tb_priority_encoder_8_3.sv
// tb_priority_encoder_8_3: scoreboard-driven self-checking bench for priority_encoder_8_3
module tb_priority_encoder_8_3;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] in = 8'd0;
  logic [2:0] out;
  logic       valid;
  logic [7:0] onehot;
  logic       multi;
  typedef struct packed {
    logic [2:0] o;
    logic       v;
    logic [7:0] oh;
    logic       m;
  } exp_t;
  exp_t q[$];
  int compared = 0;
  int mismatched = 0;
  always #5 clk = ~clk;
  priority_encoder_8_3 dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in),
    .out(out), .valid(valid), .onehot(onehot), .multi(multi)
  );
  function automatic exp_t mk(input logic [2:0] o, input logic v, input logic [7:0] oh, input logic m);
    exp_t e;
    e.o = o; e.v = v; e.oh = oh; e.m = m;
    return e;
  endfunction
  function automatic exp_t ref_enc(input logic [7:0] x);
    exp_t e;
    int   cnt;
    e = '0;
    cnt = 0;
    for (int i = 7; i >= 0; i--) begin
      if (x[i]) begin
        cnt++;
        if (!e.v) begin
          e.v  = 1'b1;
          e.o  = 3'(i);
          e.oh = '0;
          e.oh[i] = 1'b1;
        end
      end
    end
    e.m = cnt >= 2;
    return e;
  endfunction
  function automatic string fmt(input exp_t e);
    return $sformatf("out=%0d valid=%b onehot=%h multi=%b", e.o, e.v, e.oh, e.m);
  endfunction
  task automatic drive(input logic r, input logic e, input logic [7:0] x, input exp_t want);
    @(negedge clk);
    rst_n = r;
    en    = e;
    in    = x;
    q.push_back(want);
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    exp_t e, got;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 8'hFF, mk(3'd0, 1'b0, 8'h00, 1'b0));
      e = q.pop_front();
      got = {out, valid, onehot, multi};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL reset[%0d]: got %s, want %s", k, fmt(got), fmt(e));
      end
    end
  endtask
  task automatic test_walk();
    exp_t e, got;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, 8'd1 << k, mk(3'(k), 1'b1, 8'd1 << k, 1'b0));
      e = q.pop_front();
      got = {out, valid, onehot, multi};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL walk[%0d]: got %s, want %s", k, fmt(got), fmt(e));
      end
    end
  endtask
  task automatic test_priority();
    logic [7:0] vin [4] = '{8'b10100101, 8'b00010011, 8'hFF, 8'b01000001};
    exp_t       vexp[4] = '{mk(3'd7, 1'b1, 8'h80, 1'b1), mk(3'd4, 1'b1, 8'h10, 1'b1),
                            mk(3'd7, 1'b1, 8'h80, 1'b1), mk(3'd6, 1'b1, 8'h40, 1'b1)};
    exp_t e, got;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, vin[k], vexp[k]);
      e = q.pop_front();
      got = {out, valid, onehot, multi};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL priority[%h]: got %s, want %s", vin[k], fmt(got), fmt(e));
      end
    end
  endtask
  task automatic test_zero();
    exp_t e, got;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 8'(k), k == 0 ? mk(3'd0, 1'b0, 8'h00, 1'b0) : mk(3'd0, 1'b1, 8'h01, 1'b0));
      e = q.pop_front();
      got = {out, valid, onehot, multi};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL zero[%0d]: got %s, want %s", k, fmt(got), fmt(e));
      end
    end
  endtask
  task automatic test_hold();
    exp_t e, got;
    for (int k = 0; k < 5; k++) begin
      if (k == 0)
        drive(1'b1, 1'b1, 8'h40, mk(3'd6, 1'b1, 8'h40, 1'b0));
      else if (k < 4)
        drive(1'b1, 1'b0, 8'h02, mk(3'd6, 1'b1, 8'h40, 1'b0));
      else
        drive(1'b1, 1'b1, 8'h02, mk(3'd1, 1'b1, 8'h02, 1'b0));
      e = q.pop_front();
      got = {out, valid, onehot, multi};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL hold[%0d]: got %s, want %s", k, fmt(got), fmt(e));
      end
    end
  endtask
  task automatic test_exhaustive();
    exp_t e, got;
    for (int v = 0; v < 258; v++) begin
      if (v == 256)
        drive(1'b0, 1'b1, 8'hFF, mk(3'd0, 1'b0, 8'h00, 1'b0));
      else if (v == 257)
        drive(1'b1, 1'b1, 8'h0C, ref_enc(8'h0C));
      else
        drive(1'b1, 1'b1, 8'(v), ref_enc(8'(v)));
      e = q.pop_front();
      got = {out, valid, onehot, multi};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL exhaustive[%0d]: got %s, want %s", v, fmt(got), fmt(e));
      end
    end
  endtask
  task automatic test_back_to_back();
    exp_t e, got;
    drive(1'b1, 1'b1, 8'hF0, ref_enc(8'hF0));
    e = q.pop_front();
    got = {out, valid, onehot, multi};
    compared++;
    if (got !== e) begin
      mismatched++;
      $display("FAIL midreset_pre: got %s, want %s", fmt(got), fmt(e));
    end
    drive(1'b0, 1'b0, 8'h08, mk(3'd0, 1'b0, 8'h00, 1'b0));
    e = q.pop_front();
    got = {out, valid, onehot, multi};
    compared++;
    if (got !== e) begin
      mismatched++;
      $display("FAIL midreset_clear: got %s, want %s", fmt(got), fmt(e));
    end
    drive(1'b1, 1'b1, 8'h08, mk(3'd3, 1'b1, 8'h08, 1'b0));
    e = q.pop_front();
    got = {out, valid, onehot, multi};
    compared++;
    if (got !== e) begin
      mismatched++;
      $display("FAIL midreset_post: got %s, want %s", fmt(got), fmt(e));
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_walk();
    test_priority();
    test_zero();
    test_hold();
    test_exhaustive();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
